// File: rtl/xf100_ifu_fetch.sv
// ----------------------------------------------------------------------------
// xf100_ifu_fetch
//   Instruction fetch unit for the xf100 core. Owns the fetch PC and issues
//   in-order requests on a req/gnt/rvalid instruction-memory port. Returned
//   words are buffered with their PCs in a DEPTH-entry prefetch FIFO and
//   offered to decode through a valid/ready handshake. A one-cycle redirect
//   pulse flushes the FIFO, squashes in-flight fetches and restarts fetch at
//   the (aligned) target. A halt level stops new requests while in-flight
//   responses still complete and the FIFO keeps draining.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   ifu_o_instr/_pc     instruction and PC at the FIFO head
//   ifu_o_valid         head entry valid for decode
//   ifu_i_ready         decode accepts head (pop on valid & ready)
//   ifu_i_redirect      flush and restart at ifu_i_redirect_pc
//   ifu_i_redirect_pc   redirect target, low alignment bits ignored
//   ifu_i_halt          block new requests
//   ifu_o_mem_req/addr  fetch request and aligned address
//   ifu_i_mem_gnt       request accepted when req & gnt
//   ifu_i_mem_rvalid    read data valid, in request order
//   ifu_i_mem_rdata     read data
// ----------------------------------------------------------------------------
module xf100_ifu_fetch #(
    parameter int unsigned           PC_SIZE    = 32,
    parameter int unsigned           INSTR_SIZE = 32,
    parameter logic [PC_SIZE-1:0]    RESET_PC   = '0,
    parameter int unsigned           DEPTH      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [INSTR_SIZE-1:0]    ifu_o_instr,
    output logic [PC_SIZE-1:0]       ifu_o_pc,
    output logic                     ifu_o_valid,
    input  logic                     ifu_i_ready,
    input  logic                     ifu_i_redirect,
    input  logic [PC_SIZE-1:0]       ifu_i_redirect_pc,
    input  logic                     ifu_i_halt,
    output logic                     ifu_o_mem_req,
    output logic [PC_SIZE-1:0]       ifu_o_mem_addr,
    input  logic                     ifu_i_mem_gnt,
    input  logic                     ifu_i_mem_rvalid,
    input  logic [INSTR_SIZE-1:0]    ifu_i_mem_rdata
);

    localparam int unsigned STEP_BYTES = INSTR_SIZE / 8;
    localparam int unsigned ALIGN      = $clog2(STEP_BYTES);
    localparam int unsigned CW         = $clog2(DEPTH + 1);
    localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PC_SIZE-1:0] STEP       = PC_SIZE'(STEP_BYTES);
    localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~((PC_SIZE'(1) << ALIGN) - PC_SIZE'(1));
    localparam logic [PW-1:0]      PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW+1:0]      DEPTH_W    = (CW + 2)'(DEPTH);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t                 state_q;
    logic [PC_SIZE-1:0]     fetch_pc_q;
    logic [PC_SIZE-1:0]     resp_pc_q;
    logic [CW-1:0]          live_q;
    logic [CW-1:0]          drop_q;
    logic [CW-1:0]          count_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [PW-1:0]          wr_ptr_q;
    logic [INSTR_SIZE-1:0]  data_q [DEPTH];
    logic [PC_SIZE-1:0]     pc_q   [DEPTH];

    logic [CW+1:0]          occupancy;
    logic                   mem_req;
    logic                   fire;
    logic                   resp;
    logic                   resp_drop;
    logic                   push;
    logic                   head_valid;
    logic                   pop;
    logic [PC_SIZE-1:0]     target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // Credit counts every slot already promised: words queued, fetches
        // still owed to us, and squashed fetches whose data has yet to arrive.
        occupancy  = (CW + 2)'(live_q) + (CW + 2)'(drop_q) + (CW + 2)'(count_q);
        mem_req    = (state_q == RUN) && !ifu_i_halt && !ifu_i_redirect
                     && (occupancy < DEPTH_W);
        fire       = mem_req && ifu_i_mem_gnt;
        // A response with nothing outstanding is a protocol error and is ignored.
        resp       = ifu_i_mem_rvalid && ((live_q != '0) || (drop_q != '0));
        // Squashed fetches are always older than live ones, so drops retire first.
        resp_drop  = resp && (drop_q != '0);
        push       = resp && (drop_q == '0) && !ifu_i_redirect;
        head_valid = (count_q != '0) && !ifu_i_redirect;
        pop        = head_valid && ifu_i_ready;
        target     = ifu_i_redirect_pc & ALIGN_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= RESET_PC;
            end
        end else begin
            if (state_q == BOOT) begin
                state_q <= RUN;
            end

            if (ifu_i_redirect) begin
                // Everything outstanding becomes a drop; a response arriving
                // this very cycle retires one of them immediately.
                fetch_pc_q <= target;
                resp_pc_q  <= target;
                drop_q     <= drop_q + live_q + CW'(fire) - CW'(resp);
                live_q     <= '0;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (fire) begin
                    fetch_pc_q <= fetch_pc_q + STEP;
                end
                live_q  <= live_q + CW'(fire) - CW'(push);
                drop_q  <= drop_q - CW'(resp_drop);
                count_q <= count_q + CW'(push) - CW'(pop);
                if (push) begin
                    data_q[wr_ptr_q] <= ifu_i_mem_rdata;
                    pc_q[wr_ptr_q]   <= resp_pc_q;
                    wr_ptr_q         <= ptr_inc(wr_ptr_q);
                    resp_pc_q        <= resp_pc_q + STEP;
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
            end
        end
    end

    assign ifu_o_mem_req  = mem_req;
    assign ifu_o_mem_addr = fetch_pc_q;
    assign ifu_o_valid    = head_valid;
    assign ifu_o_instr    = data_q[rd_ptr_q];
    assign ifu_o_pc       = pc_q[rd_ptr_q];

endmodule
